// File: rtl/image_rom_streamer_if.sv
// ============================================================================
// Module      : image_rom_streamer_if
// Description : Bundles the image ROM read port and the outgoing pixel stream
//               of image_rom_streamer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   rom_addr  [AW]     read address to the synchronous image ROM
//   rom_rd    [WIDTH]  ROM read data, one cycle after the address is sampled
//   pix_data  [WIDTH]  stream pixel
//   pix_valid          pixel valid
//   pix_ready          downstream accept (transfer = pix_valid & pix_ready)
//   pix_sof            first pixel of the frame
//   pix_last           final pixel of the frame
//   pix_eol            final pixel of a row (only with IMAGE_STREAM_EOL_EN)
// Modports: master = streamer side, slave = ROM/sink side.
// Optional macro: IMAGE_STREAM_EOL_EN adds pix_eol.
// ============================================================================
`default_nettype none

interface image_rom_streamer_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 32
);
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_rd;
  logic [WIDTH-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic             pix_last;
`ifdef IMAGE_STREAM_EOL_EN
  logic             pix_eol;
`endif

  modport master (
    output rom_addr,
    input  rom_rd,
    output pix_data,
    output pix_valid,
    input  pix_ready,
    output pix_sof,
    output pix_last
`ifdef IMAGE_STREAM_EOL_EN
    , output pix_eol
`endif
  );

  modport slave (
    input  rom_addr,
    output rom_rd,
    input  pix_data,
    input  pix_valid,
    output pix_ready,
    input  pix_sof,
    input  pix_last
`ifdef IMAGE_STREAM_EOL_EN
    , input pix_eol
`endif
  );
endinterface

`default_nettype wire

// File: rtl/image_rom_streamer.sv
// ============================================================================
// Module      : image_rom_streamer
// Description : Reads a complete IMG_W x IMG_H frame from a synchronous image
//               ROM (1-cycle latency) in raster order and presents it as a
//               valid/ready pixel stream. A 2-entry output buffer absorbs the
//               ROM latency so backpressure never drops or repeats a pixel.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   frame request, sampled only while idle
//   busy   out  high from frame accept until the final pixel handshake
//   done   out  one-cycle pulse after the final pixel handshake
//   bus    master modport of image_rom_streamer_if (ROM port + pixel stream)
// Optional macro: IMAGE_STREAM_EOL_EN adds the pix_eol row-end marker.
// ============================================================================
`default_nettype none

module image_rom_streamer #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  output logic                   busy,
  output logic                   done,
  image_rom_streamer_if.master   bus
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    issue_cnt_q;

  // Read in flight: tags are captured at issue and ride along with the data.
  logic             infl_q;
  logic             infl_sof_q;
  logic             infl_last_q;

  // 2-entry output FIFO.
  logic [WIDTH-1:0] data_q [2];
  logic [1:0]       sof_q;
  logic [1:0]       last_q;
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       occ_q;

`ifdef IMAGE_STREAM_EOL_EN
  localparam int COLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_W - 1);
  logic [COLW-1:0]  col_q;
  logic             infl_eol_q;
  logic [1:0]       eol_q;
`endif

  logic             valid;
  logic             pop;
  logic             frame_end;
  logic [2:0]       level;
  logic             issue;
  logic [1:0]       occ_d;

  always_comb begin
    valid     = (occ_q != 2'd0);
    pop       = valid & bus.pix_ready;
    frame_end = pop & last_q[rd_ptr_q];
    // Issue only if the returning word is guaranteed a free slot:
    // occupancy + in-flight - pop must stay <= 1.
    level     = {1'b0, occ_q} + {2'b00, infl_q};
    issue     = (state_q == ST_RUN) && (issue_cnt_q < N_CNT) &&
                (level <= (3'd1 + {2'b00, pop}));
    occ_d     = occ_q + {1'b0, infl_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_cnt_q <= '0;
      infl_q      <= 1'b0;
      infl_sof_q  <= 1'b0;
      infl_last_q <= 1'b0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      sof_q       <= '0;
      last_q      <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= '0;
`ifdef IMAGE_STREAM_EOL_EN
      col_q       <= '0;
      infl_eol_q  <= 1'b0;
      eol_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            issue_cnt_q <= '0;
`ifdef IMAGE_STREAM_EOL_EN
            col_q       <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + CW'(1);
`ifdef IMAGE_STREAM_EOL_EN
            col_q       <= (col_q == COL_LAST) ? '0 : col_q + COLW'(1);
`endif
          end
          // Every read has been issued by the time the last pixel leaves,
          // so returning the address to 0 here cannot collide with an issue.
          if (frame_end) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            issue_cnt_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      infl_q      <= issue;
      infl_sof_q  <= (issue_cnt_q == '0);
      infl_last_q <= (issue_cnt_q == LAST_IDX);
`ifdef IMAGE_STREAM_EOL_EN
      infl_eol_q  <= (col_q == COL_LAST);
`endif

      if (infl_q) begin
        data_q[wr_ptr_q] <= bus.rom_rd;
        sof_q[wr_ptr_q]  <= infl_sof_q;
        last_q[wr_ptr_q] <= infl_last_q;
`ifdef IMAGE_STREAM_EOL_EN
        eol_q[wr_ptr_q]  <= infl_eol_q;
`endif
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.rom_addr  = AW'(issue_cnt_q);
  assign bus.pix_data  = data_q[rd_ptr_q];
  assign bus.pix_valid = valid;
  assign bus.pix_sof   = valid & sof_q[rd_ptr_q];
  assign bus.pix_last  = valid & last_q[rd_ptr_q];
`ifdef IMAGE_STREAM_EOL_EN
  assign bus.pix_eol   = valid & eol_q[rd_ptr_q];
`endif

endmodule

`default_nettype wire

// File: tb/tb_image_rom_streamer.sv
// ============================================================================
// Module      : tb_image_rom_streamer
// Description : Directed self-checking bench for image_rom_streamer with a
//               4x4 frame and a ROM holding rom[i] = i.
// Revision    : 1.0 - initial release
// Optional macro: IMAGE_STREAM_EOL_EN enables pix_eol checks.
// ============================================================================
`default_nettype none

module tb_image_rom_streamer;

  localparam int W    = 8;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int AW   = 32;
  localparam int NPIX = IW * IH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic eol_obs;

  int checks = 0;
  int errors = 0;

  image_rom_streamer_if #(.WIDTH(W), .AW(AW)) bus ();

  image_rom_streamer #(
    .WIDTH(W), .IMG_W(IW), .IMG_H(IH), .AW(AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, rom[i] = i.
  always @(posedge clk) bus.rom_rd <= bus.rom_addr[W-1:0];

`ifdef IMAGE_STREAM_EOL_EN
  assign eol_obs = bus.pix_eol;
`else
  assign eol_obs = 1'b0;
`endif

  function automatic logic exp_eol(input int k);
`ifdef IMAGE_STREAM_EOL_EN
    return (k % IW) == (IW - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    rst_n = 1'b0;
    start = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (3) tick();
    flags = {busy, done, bus.pix_valid, bus.pix_sof, bus.pix_last | eol_obs};
    checks++;
    if (flags !== 5'b0 || bus.pix_data !== 8'd0 || bus.rom_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: got flags=%b data=%0d addr=%0d expected all 0",
               flags, bus.pix_data, bus.rom_addr);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      flags = {busy, done, bus.pix_valid, bus.pix_sof, bus.pix_last | eol_obs};
      checks++;
      if (flags !== 5'b0 || bus.pix_data !== 8'd0 || bus.rom_addr !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d: got flags=%b data=%0d addr=%0d expected all 0",
                 c, flags, bus.pix_data, bus.rom_addr);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [11:0] got, exp;
    bus.pix_ready = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bus.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL ff_accept: got busy=%b valid=%b expected busy=1 valid=0", busy, bus.pix_valid);
    end
    tick();
    checks++;
    if (bus.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL ff_latency1: got valid=%b expected 0", bus.pix_valid);
    end
    tick();
    for (int k = 0; k < NPIX; k++) begin
      got = {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_last, eol_obs};
      exp = {1'b1, 8'(k), (k == 0), (k == NPIX - 1), exp_eol(k)};
      checks++;
      if (got !== exp || done !== 1'b0) begin
        errors++;
        $display("FAIL ff_pixel k=%0d: got {v,d,sof,last,eol}=%h done=%b expected %h done=0",
                 k, got, done, exp);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.rom_addr !== 32'd0) begin
      errors++;
      $display("FAIL ff_done: got done=%b busy=%b valid=%b addr=%0d expected 1 0 0 0",
               done, busy, bus.pix_valid, bus.rom_addr);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL ff_done_pulse: got done=%b expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pattern;
    logic [11:0] cur, prev;
    logic        prev_stall;
    int          exp;
    pattern    = 32'hA5C3_96E1;
    exp        = 0;
    prev       = '0;
    prev_stall = 1'b0;
    bus.pix_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 300 && exp < NPIX; c++) begin
      bus.pix_ready = pattern[c % 32];
      cur = {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_last, eol_obs};
      if (prev_stall) begin
        checks++;
        if (cur !== prev) begin
          errors++;
          $display("FAIL bp_stable c=%0d: got %h expected %h", c, cur, prev);
        end
      end
      checks++;
      if (dut.occ_q > 2'd2) begin
        errors++;
        $display("FAIL bp_occupancy c=%0d: got %0d expected <= 2", c, dut.occ_q);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        checks++;
        if (cur !== {1'b1, 8'(exp), (exp == 0), (exp == NPIX - 1), exp_eol(exp)}) begin
          errors++;
          $display("FAIL bp_pixel idx=%0d: got {v,d,sof,last,eol}=%h expected data %0d", exp, cur, exp);
        end
        exp++;
      end
      prev       = cur;
      prev_stall = bus.pix_valid & ~bus.pix_ready;
      tick();
    end
    checks++;
    if (exp != NPIX || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_complete: got %0d pixels done=%b expected %0d pixels done=1", exp, done, NPIX);
    end
    bus.pix_ready = 1'b1;
    tick();
  endtask

  task automatic test_long_stall();
    int exp;
    bus.pix_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 20 && !(bus.pix_valid && bus.pix_data == 8'd3); c++) tick();
    checks++;
    if (!(bus.pix_valid && bus.pix_data == 8'd3)) begin
      errors++;
      $display("FAIL ls_reach3: got valid=%b data=%0d expected valid=1 data=3",
               bus.pix_valid, bus.pix_data);
    end
    bus.pix_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'd3 || bus.rom_addr > 32'd5 ||
          bus.pix_sof !== 1'b0 || bus.pix_last !== 1'b0 || eol_obs !== exp_eol(3)) begin
        errors++;
        $display("FAIL ls_hold c=%0d: got valid=%b data=%0d addr=%0d sof=%b last=%b expected 1 3 <=5 0 0",
                 c, bus.pix_valid, bus.pix_data, bus.rom_addr, bus.pix_sof, bus.pix_last);
      end
    end
    bus.pix_ready = 1'b1;
    exp = 3;
    for (int c = 0; c < 40 && exp < NPIX; c++) begin
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'(exp)) begin
        errors++;
        $display("FAIL ls_resume idx=%0d: got valid=%b data=%0d expected 1 %0d",
                 exp, bus.pix_valid, bus.pix_data, exp);
      end
      exp++;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ls_done: got %b expected 1", done);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int exp;
    exp = 0;
    bus.pix_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 60 && exp < NPIX; c++) begin
      start = (c == 5 || c == 6);
      if (bus.pix_valid) begin
        checks++;
        if (bus.pix_data !== 8'(exp)) begin
          errors++;
          $display("FAIL swb_pixel idx=%0d: got %0d expected %0d", exp, bus.pix_data, exp);
        end
        exp++;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (exp != NPIX || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL swb_done: got pixels=%0d done=%b busy=%b expected %0d 1 0", exp, done, busy, NPIX);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL swb_idle: got busy=%b done=%b valid=%b expected 0 0 0", busy, done, bus.pix_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    bus.pix_ready = 1'b1;
    pulse_start();
    exp = 0;
    for (int c = 0; c < 40 && exp < NPIX; c++) begin
      if (bus.pix_valid) exp++;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1: got %b expected 1", done);
    end
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bus.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b valid=%b expected 1 0", busy, bus.pix_valid);
    end
    tick();
    tick();
    exp = 0;
    for (int c = 0; c < 40 && exp < NPIX; c++) begin
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'(exp) || bus.pix_sof !== (exp == 0)) begin
        errors++;
        $display("FAIL b2b_pixel idx=%0d: got valid=%b data=%0d sof=%b expected 1 %0d %b",
                 exp, bus.pix_valid, bus.pix_data, bus.pix_sof, exp, (exp == 0));
      end
      exp++;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done2: got %b expected 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] flags;
    bus.pix_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 20 && !(bus.pix_valid && bus.pix_data == 8'd7); c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    flags = {busy, done, bus.pix_valid, bus.pix_sof, bus.pix_last | eol_obs};
    checks++;
    if (flags !== 5'b0 || bus.pix_data !== 8'd0 || bus.rom_addr !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got flags=%b data=%0d addr=%0d expected all 0",
               flags, bus.pix_data, bus.rom_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    tick();
    checks++;
    if (bus.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart_lat: got valid=%b expected 0", bus.pix_valid);
    end
    tick();
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'd0 || bus.pix_sof !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: got valid=%b data=%0d sof=%b expected 1 0 1",
               bus.pix_valid, bus.pix_data, bus.pix_sof);
    end
    repeat (NPIX + 2) tick();
  endtask

  initial begin
    bus.pix_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_long_stall();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
